encoder_frame_serializer: RTL and testbench

//  Upstream feeder for the K=3..7 rate-1/2 convolutional encoder.
//  - Accepts a frame of bytes over a valid/ready handshake.
//  - Emits the bytes MSB-first, one bit per clock, on unencoded_bit.
//  - Appends K-1 zero tail bits so the encoder's shift register is flushed to state 0.
//  - Drives framing strobes so the encoder's output can be delimited downstream.

---
 rtl/encoder_frame_serializer.sv | 162 ++++++++++++++++
 tb/tb_encoder_frame_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_frame_serializer.sv
// encoder_frame_serializer
//   Feeds a K=3..7 rate-1/2 convolutional encoder. A frame of frame_len words
//   is accepted over a valid/ready handshake, shifted out MSB-first one bit per
//   clock, and followed by Keff-1 zero tail bits that flush the encoder to
//   state 0. All outputs are registered.
// Ports
//   clk                       rising-edge clock
//   rst                       asynchronous active-low reset
//   start                     frame request, sampled in IDLE only
//   frame_len                 words in frame (0 ignored), sampled with start
//   choose_constraint_length  K, sampled with start; values <3 treated as 3
//   in_data / in_valid        input word and its valid
//   in_ready                  word is accepted this cycle when in_valid=1
//   unencoded_bit             serial bit to encoder (0 whenever bit_valid=0)
//   bit_valid                 unencoded_bit is a frame bit (encoder enable)
//   frame_start               with the first data bit of a frame
//   frame_end                 with the last tail bit of a frame
//   busy                      state is not IDLE
module encoder_frame_serializer #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [2:0]        choose_constraint_length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              unencoded_bit,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, TAIL} state_t;

  state_t             state, state_nx;
  logic [LEN_W-1:0]   words_left, words_left_nx;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nx;      // bits still to emit after the one shown
  logic [DATA_W-1:0]  shreg, shreg_nx;          // remaining bits, next one at MSB
  logic [2:0]         keff_m1, keff_m1_nx;      // tail length Keff-1
  logic [2:0]         tail_left, tail_left_nx;  // tail bits still to emit after the one shown
  logic               first_word, first_word_nx;
  logic               ready_nx, ubit_nx, bv_nx, fs_nx, fe_nx, busy_nx;
  logic               do_accept;

  always_comb begin
    state_nx      = state;
    words_left_nx = words_left;
    bit_cnt_nx    = bit_cnt;
    shreg_nx      = shreg;
    keff_m1_nx    = keff_m1;
    tail_left_nx  = tail_left;
    first_word_nx = first_word;
    ready_nx      = 1'b0;
    ubit_nx       = 1'b0;
    bv_nx         = 1'b0;
    fs_nx         = 1'b0;
    fe_nx         = 1'b0;
    do_accept     = 1'b0;

    case (state)
      IDLE: begin
        if (start && frame_len != '0) begin
          words_left_nx = frame_len;
          keff_m1_nx    = (choose_constraint_length < 3'd3) ? 3'd2
                                                            : choose_constraint_length - 3'd1;
          first_word_nx = 1'b1;
          state_nx      = LOAD;
          ready_nx      = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid && in_ready) do_accept = 1'b1;
        else                      ready_nx  = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt != '0) begin
          ubit_nx    = shreg[DATA_W-1];
          shreg_nx   = {shreg[DATA_W-2:0], 1'b0};
          bit_cnt_nx = bit_cnt - 1'b1;
          bv_nx      = 1'b1;
          // Raise ready together with the last bit so a waiting word follows without a bubble.
          ready_nx   = (bit_cnt == CNT_W'(1)) && (words_left != '0);
        end else if (in_valid && in_ready) begin
          do_accept = 1'b1;
        end else if (words_left != '0) begin
          state_nx = LOAD;
          ready_nx = 1'b1;
        end else begin
          state_nx     = TAIL;
          bv_nx        = 1'b1;
          tail_left_nx = keff_m1 - 3'd1;
          fe_nx        = (keff_m1 == 3'd1);
        end
      end
      TAIL: begin
        if (tail_left != '0) begin
          bv_nx        = 1'b1;
          tail_left_nx = tail_left - 3'd1;
          fe_nx        = (tail_left == 3'd1);
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Word capture is shared by LOAD and the last-bit cycle of SHIFT;
    // the MSB goes straight to the output register, the rest to shreg.
    if (do_accept) begin
      state_nx      = SHIFT;
      ubit_nx       = in_data[DATA_W-1];
      shreg_nx      = {in_data[DATA_W-2:0], 1'b0};
      bit_cnt_nx    = CNT_W'(DATA_W - 1);
      words_left_nx = words_left - 1'b1;
      bv_nx         = 1'b1;
      fs_nx         = first_word;
      first_word_nx = 1'b0;
    end

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      words_left    <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      keff_m1       <= '0;
      tail_left     <= '0;
      first_word    <= 1'b0;
      in_ready      <= 1'b0;
      unencoded_bit <= 1'b0;
      bit_valid     <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      words_left    <= words_left_nx;
      bit_cnt       <= bit_cnt_nx;
      shreg         <= shreg_nx;
      keff_m1       <= keff_m1_nx;
      tail_left     <= tail_left_nx;
      first_word    <= first_word_nx;
      in_ready      <= ready_nx;
      unencoded_bit <= ubit_nx;
      bit_valid     <= bv_nx;
      frame_start   <= fs_nx;
      frame_end     <= fe_nx;
      busy          <= busy_nx;
    end
  end

endmodule

// File: tb/tb_encoder_frame_serializer.sv
// Testbench for encoder_frame_serializer. Each frame is described as a list
// of words and a per-word stall; from that the expected per-cycle waveform
// (ready windows, bit stream, gaps, strobes, busy) is laid out in arrays.
module tb_encoder_frame_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_len = '0;
  logic [2:0] k_sel = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, unencoded_bit, bit_valid, frame_start, frame_end, busy;

  encoder_frame_serializer #(.DATA_W(8), .LEN_W(8)) dut (
    .clk                      (clk),
    .rst                      (rst_n),
    .start                    (start),
    .frame_len                (frame_len),
    .choose_constraint_length (k_sel),
    .in_data                  (in_data),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .unencoded_bit            (unencoded_bit),
    .bit_valid                (bit_valid),
    .frame_start              (frame_start),
    .frame_end                (frame_end),
    .busy                     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam int MAXC = 2048;
  logic       e_rdy[MAXC], e_bv[MAXC], e_bit[MAXC], e_fs[MAXC], e_fe[MAXC], e_busy[MAXC];
  logic       d_val[MAXC];
  logic [7:0] d_dat[MAXC];
  logic [7:0] wq[64];
  int         stl[64];

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag, input int cyc);
    chk({tag, "_rdy"},   cyc, in_ready,      1'b0);
    chk({tag, "_bit"},   cyc, unencoded_bit, 1'b0);
    chk({tag, "_bv"},    cyc, bit_valid,     1'b0);
    chk({tag, "_fs"},    cyc, frame_start,   1'b0);
    chk({tag, "_fe"},    cyc, frame_end,     1'b0);
    chk({tag, "_busy"},  cyc, busy,          1'b0);
  endtask

  // Run one frame of nw words (wq/stl preloaded). noise=1 scrambles ignored
  // inputs (start, frame_len, K, in_valid/in_data outside ready windows).
  // abort_at>=0 drops reset in that frame cycle and ends the frame there.
  task automatic run_frame(input int nw, input int kin, input bit noise, input int abort_at);
    int keff, r, s, last, ncyc;
    logic [7:0] w;
    keff = (kin < 3) ? 3 : kin;
    for (int c = 0; c < MAXC; c++) begin
      e_rdy[c] = 0; e_bv[c] = 0; e_bit[c] = 0; e_fs[c] = 0; e_fe[c] = 0; e_busy[c] = 0;
      d_val[c] = noise ? 1'($urandom) : 1'b0;
      d_dat[c] = noise ? 8'($urandom) : 8'h00;
    end
    // Word i is requested from cycle r (LOAD for word 0, last bit of the
    // previous word otherwise); in_valid stays low stl[i] cycles, then the
    // bits follow one cycle after the accepting cycle.
    r = 0; last = 0;
    for (int i = 0; i < nw; i++) begin
      s = stl[i];
      if (i > 0) r = last;
      for (int j = 0; j <= s; j++) begin
        e_rdy[r+j] = 1'b1;
        d_val[r+j] = (j == s);
        if (j == s) d_dat[r+j] = wq[i];
      end
      w = wq[i];
      for (int b = 0; b < 8; b++) begin
        e_bv[r+s+1+b]  = 1'b1;
        e_bit[r+s+1+b] = w[7-b];
        e_fs[r+s+1+b]  = (i == 0) && (b == 0);
      end
      last = r + s + 8;
    end
    for (int t = 1; t < keff; t++) e_bv[last+t] = 1'b1;
    e_fe[last+keff-1] = 1'b1;
    ncyc = last + keff;
    for (int c = 0; c < ncyc; c++) e_busy[c] = 1'b1;

    @(negedge clk);
    start = 1'b1; frame_len = 8'(nw); k_sel = 3'(kin);
    in_valid = noise ? 1'($urandom) : 1'b0;
    for (int c = 0; c < ncyc + 2; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort", c);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; frame_len = '0;
        for (int q = 0; q < 3; q++) begin
          @(negedge clk);
          chk_all_zero("post_abort", c + 1 + q);
        end
        return;
      end
      chk("in_ready",    c, in_ready,      e_rdy[c]);
      chk("bit_valid",   c, bit_valid,     e_bv[c]);
      chk("bit",         c, unencoded_bit, e_bit[c]);
      chk("frame_start", c, frame_start,   e_fs[c]);
      chk("frame_end",   c, frame_end,     e_fe[c]);
      chk("busy",        c, busy,          e_busy[c]);
      if (c >= ncyc) begin
        start = noise; frame_len = '0;
      end else begin
        start     = noise ? 1'($urandom) : 1'b0;
        frame_len = noise ? 8'($urandom_range(1, 255)) : 8'(nw);
      end
      k_sel    = noise ? 3'($urandom) : 3'(kin);
      in_valid = d_val[c];
      in_data  = d_dat[c];
    end
    start = 1'b0; frame_len = '0; in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset", 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset", 0);

    // 1: K=3, single word 0xA5
    wq[0] = 8'hA5; stl[0] = 0;
    run_frame(1, 3, 1'b0, -1);

    // 2: K=3, 0xFF then 0x00 back to back
    wq[0] = 8'hFF; wq[1] = 8'h00; stl[0] = 0; stl[1] = 0;
    run_frame(2, 3, 1'b0, -1);

    // 3: three-cycle stall before word 2
    wq[0] = 8'h3C; wq[1] = 8'hC3; stl[0] = 0; stl[1] = 3;
    run_frame(2, 3, 1'b0, -1);

    // 4: K=7 and K=0 (clamped); inputs including K scrambled mid-frame
    wq[0] = 8'h96; stl[0] = 1;
    run_frame(1, 7, 1'b1, -1);
    wq[0] = 8'h5A; wq[1] = 8'h81; stl[0] = 0; stl[1] = 0;
    run_frame(2, 0, 1'b1, -1);

    // 5: start with frame_len=0 is ignored
    @(negedge clk);
    start = 1'b1; frame_len = '0; k_sel = 3'd5; in_valid = 1'b1;
    for (int q = 0; q < 3; q++) begin
      @(negedge clk);
      chk("len0_busy",  q, busy,     1'b0);
      chk("len0_ready", q, in_ready, 1'b0);
    end
    start = 1'b0; in_valid = 1'b0;

    // 6: reset on the fifth data bit, then a clean 0xA5 frame
    wq[0] = 8'hA5; stl[0] = 0;
    run_frame(1, 3, 1'b0, 5);
    run_frame(1, 3, 1'b0, -1);

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      int nw;
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) begin
        wq[i]  = 8'($urandom);
        stl[i] = $urandom_range(0, 3);
      end
      run_frame(nw, $urandom_range(0, 7), 1'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
